imem_fetch_arbiter: RTL and testbench

Shares the single combinational-read instruction memory port between NUM_REQ core fetch units using round-robin arbitration. Each grant registers the winner's byte address, drives it word-aligned to the memory and registers the returned word. The winner then sees a one-cycle rvalid pulse. The block sits between the per-core fetch stages and the shared instruction memory, and can be halted while the program image is loaded.

---
 rtl/imem_fetch_if.sv | 19 +
 rtl/imem_fetch_arbiter.sv | 74 +++++++
 tb/tb_imem_fetch_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_if.sv
// imem_fetch_if: fetch-unit request/response bundle plus the shared instruction-memory port
interface imem_fetch_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  logic                      halt;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;
  logic                      err;
  logic                      busy;
  logic [ADDR_W-1:0]         mem_a;
  logic [DATA_W-1:0]         mem_rd;
  modport slave (input halt, req, addr, mem_rd, output gnt, rvalid, rdata, err, busy, mem_a);
  modport master (output halt, req, addr, mem_rd, input gnt, rvalid, rdata, err, busy, mem_a);
endinterface

// File: rtl/imem_fetch_arbiter.sv
// imem_fetch_arbiter: round-robin sharing of one combinational-read instruction memory port
module imem_fetch_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 64
) (
  input logic         clk,
  input logic         rst,
  imem_fetch_if.slave bus
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;
  state_t state, state_nx;
  logic [IW-1:0] rr_ptr, win;
  logic [IW:0] s;
  logic found, take, oor, mis, err_q, oor_q;
  logic [NUM_REQ-1:0] elig;
  logic [ADDR_W-1:0] win_addr;
  logic [ADDR_W-1:0] a [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_a
    assign a[i] = bus.addr[i*ADDR_W +: ADDR_W];
  end
  // the requester being answered in RESP must not win again in that same cycle
  assign elig = bus.req & ~(state == RESP ? bus.rvalid : '0);
  always_comb begin
    found = 1'b0;
    win = '0;
    win_addr = '0;
    s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s = {1'b0, rr_ptr} + (IW+1)'(k);
      s = s >= (IW+1)'(NUM_REQ) ? s - (IW+1)'(NUM_REQ) : s;
      if (!found && elig[s[IW-1:0]]) begin
        found = 1'b1;
        win = s[IW-1:0];
        win_addr = a[s[IW-1:0]];
      end
    end
  end
  assign oor = win_addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH);
  assign mis = |win_addr[1:0];
  assign take = found && !bus.halt && state != FETCH;
  assign bus.busy = state != IDLE;
  always_comb state_nx = state == FETCH ? RESP : take ? FETCH : IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      bus.gnt <= '0;
      bus.rvalid <= '0;
      bus.rdata <= '0;
      bus.err <= 1'b0;
      bus.mem_a <= '0;
      err_q <= 1'b0;
      oor_q <= 1'b0;
    end else begin
      bus.rvalid <= state == FETCH ? bus.gnt : '0;
      if (state == FETCH) begin
        bus.rdata <= oor_q ? '0 : bus.mem_rd;
        bus.err <= err_q;
        bus.gnt <= '0;
      end else if (take) begin
        bus.gnt <= NUM_REQ'(1) << win;
        bus.mem_a <= {win_addr[ADDR_W-1:2], 2'b00};
        err_q <= oor | mis;
        oor_q <= oor;
        rr_ptr <= win == IW'(NUM_REQ-1) ? '0 : win + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// tb_imem_fetch_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_imem_fetch_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  imem_fetch_if #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(32)) bus();
  imem_fetch_arbiter #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(32), .DEPTH(64)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mem_rd = bus.mem_a[31:2] < 30'd64 ? 32'hA500_0000 + {2'b00, bus.mem_a[31:2]} : 32'hDEAD_BEEF;

  function automatic logic [31:0] word_of(logic [31:0] x);
    return (x >> 2) < 64 ? 32'hA500_0000 + (x >> 2) : 32'h0;
  endfunction

  // model: a grant occupies the following edge to complete; the winner sits out the edge after delivery
  int m_ptr, m_fl, m_excl, w, idx;
  logic [31:0] m_fa, m_rdata, m_mema;
  logic [3:0] m_gnt, m_rvalid;
  logic m_err, m_busy;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr = 0; m_fl = -1; m_excl = -1; m_fa = 0;
      m_gnt = 0; m_rvalid = 0; m_rdata = 0; m_err = 0; m_mema = 0; m_busy = 0;
    end else if (m_fl >= 0) begin
      m_rvalid = 4'b1 << m_fl;
      m_rdata = word_of(m_fa);
      m_err = (m_fa >> 2) >= 64 || m_fa[1:0] != 2'b00;
      m_gnt = 0; m_excl = m_fl; m_fl = -1; m_busy = 1;
    end else begin
      w = -1;
      m_rvalid = 0;
      if (!bus.halt)
        for (int k = 0; k < 4; k++) begin
          idx = (m_ptr + k) % 4;
          if (w < 0 && bus.req[idx] && idx != m_excl) w = idx;
        end
      m_excl = -1;
      if (w >= 0) begin
        m_fl = w; m_fa = bus.addr[w*32 +: 32]; m_gnt = 4'b1 << w;
        m_mema = {m_fa[31:2], 2'b00}; m_ptr = (w + 1) % 4; m_busy = 1;
      end else m_busy = 0;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.req = 0; bus.halt = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.req = 0; bus.halt = 0; bus.addr = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.gnt, bus.rvalid, bus.rdata, bus.err, bus.busy, bus.mem_a} !== 75'b0) begin
      failures++;
      $display("FAIL reset_outputs got gnt=%b rvalid=%b rdata=%h err=%b busy=%b mem_a=%h required all zero",
               bus.gnt, bus.rvalid, bus.rdata, bus.err, bus.busy, bus.mem_a);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    bus.req = 4'b0001; bus.addr[31:0] = 32'h8;
    @(negedge clk);
    checks++;
    if (bus.gnt !== 4'b0001 || bus.mem_a !== 32'h8 || bus.rvalid !== 4'b0) begin
      failures++;
      $display("FAIL single_grant got gnt=%b mem_a=%h rvalid=%b required 0001/00000008/0000", bus.gnt, bus.mem_a, bus.rvalid);
    end
    @(negedge clk);
    checks++;
    if (bus.rvalid !== 4'b0001 || bus.rdata !== 32'hA500_0002 || bus.err !== 1'b0 || bus.gnt !== 4'b0) begin
      failures++;
      $display("FAIL single_resp got rvalid=%b rdata=%h err=%b gnt=%b required 0001/a5000002/0/0000", bus.rvalid, bus.rdata, bus.err, bus.gnt);
    end
    bus.req = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.req = 4'b1111; bus.addr = {32'hC, 32'h8, 32'h4, 32'h0};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (bus.gnt !== 4'b1 << (k % 4) || bus.rvalid !== 4'b0) begin
        failures++;
        $display("FAIL b2b_grant_%0d got gnt=%b rvalid=%b required gnt=%b", k, bus.gnt, bus.rvalid, 4'b1 << (k % 4));
      end
      @(negedge clk);
      checks++;
      if (bus.rvalid !== 4'b1 << (k % 4) || bus.rdata !== 32'hA500_0000 + k % 4 || bus.gnt !== 4'b0 || bus.err !== 1'b0) begin
        failures++;
        $display("FAIL b2b_resp_%0d got rvalid=%b rdata=%h gnt=%b err=%b required rvalid=%b rdata=%h", k, bus.rvalid, bus.rdata,
                 bus.gnt, bus.err, 4'b1 << (k % 4), 32'hA500_0000 + k % 4);
      end
    end
    bus.req = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_errors();
    do_reset();
    bus.req = 4'b0010; bus.addr[63:32] = 32'h6;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.rvalid !== 4'b0010 || bus.rdata !== 32'hA500_0001 || bus.err !== 1'b1) begin
      failures++;
      $display("FAIL misaligned got rvalid=%b rdata=%h err=%b required 0010/a5000001/1", bus.rvalid, bus.rdata, bus.err);
    end
    bus.req = 4'b0100; bus.addr[95:64] = 32'h100;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.rvalid !== 4'b0100 || bus.rdata !== 32'h0 || bus.err !== 1'b1) begin
      failures++;
      $display("FAIL out_of_range got rvalid=%b rdata=%h err=%b required 0100/00000000/1", bus.rvalid, bus.rdata, bus.err);
    end
    bus.req = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_halt();
    do_reset();
    bus.req = 4'b1111; bus.addr = {32'hC, 32'h8, 32'h4, 32'h0};
    repeat (7) @(negedge clk);
    checks++;
    if (bus.gnt !== 4'b1000) begin
      failures++;
      $display("FAIL halt_pre_grant got gnt=%b required 1000", bus.gnt);
    end
    bus.halt = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.rvalid !== 4'b1000 || bus.rdata !== 32'hA500_0003) begin
      failures++;
      $display("FAIL halt_inflight got rvalid=%b rdata=%h required 1000/a5000003", bus.rvalid, bus.rdata);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (bus.gnt !== 4'b0 || bus.rvalid !== 4'b0 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL halt_hold_%0d got gnt=%b rvalid=%b busy=%b required 0000/0000/0", k, bus.gnt, bus.rvalid, bus.busy);
      end
    end
    bus.halt = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.gnt !== 4'b0001) begin
      failures++;
      $display("FAIL halt_resume got gnt=%b required 0001", bus.gnt);
    end
    bus.req = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_fetch();
    bus.req = 4'b0100; bus.addr[95:64] = 32'h10;
    @(negedge clk);
    checks++;
    if (bus.gnt !== 4'b0100) begin
      failures++;
      $display("FAIL rstf_grant got gnt=%b required 0100", bus.gnt);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.gnt, bus.rvalid, bus.rdata, bus.err, bus.busy, bus.mem_a} !== 75'b0) begin
      failures++;
      $display("FAIL rstf_async got gnt=%b rvalid=%b rdata=%h err=%b busy=%b mem_a=%h required all zero",
               bus.gnt, bus.rvalid, bus.rdata, bus.err, bus.busy, bus.mem_a);
    end
    @(negedge clk);
    checks++;
    if (bus.rvalid !== 4'b0) begin
      failures++;
      $display("FAIL rstf_no_rvalid got rvalid=%b required 0000", bus.rvalid);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.gnt !== 4'b0100) begin
      failures++;
      $display("FAIL rstf_regrant got gnt=%b required 0100", bus.gnt);
    end
    bus.req = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    logic [3:0] held = 0;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      checks++;
      if (bus.gnt !== m_gnt || bus.rvalid !== m_rvalid || bus.busy !== m_busy || bus.mem_a !== m_mema ||
          bus.rdata !== m_rdata || bus.err !== m_err || $countones(bus.gnt) > 1) begin
        failures++;
        $display("FAIL random_cycle_%0d got gnt=%b rvalid=%b busy=%b mem_a=%h rdata=%h err=%b required gnt=%b rvalid=%b busy=%b mem_a=%h rdata=%h err=%b",
                 n, bus.gnt, bus.rvalid, bus.busy, bus.mem_a, bus.rdata, bus.err, m_gnt, m_rvalid, m_busy, m_mema, m_rdata, m_err);
      end
      if ($urandom_range(0, 1) == 0) held &= ~bus.rvalid;
      held |= 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      bus.req = held;
      for (int i = 0; i < 4; i++) bus.addr[i*32 +: 32] = $urandom_range(0, 32'h11F);
      bus.halt = $urandom_range(0, 9) == 0;
    end
    bus.req = 0; bus.halt = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_errors();
    test_halt();
    test_reset_fetch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
